// File: rtl/two_mode_timer.sv
// Two-mode timer core: count-up stopwatch (ModeSel=0) or preset countdown (ModeSel=1).
// A run/pause/done FSM is driven by StartStop rising edges and the Clear level.
module two_mode_timer #(
   parameter int MAX_MIN  = 99,
   parameter int SEC_WRAP = 60
) (
   input  logic       CLK_1Hz,
   input  logic       Reset,
   input  logic       ModeSel,
   input  logic [2:0] TimeControl,
   input  logic       StartStop,
   input  logic       Clear,
   output logic [7:0] MSB,
   output logic [7:0] LSB,
   output logic       Stopped,
   output logic       Expired,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

   localparam logic [7:0] MAX_M    = 8'(MAX_MIN);
   localparam logic [7:0] SEC_LAST = 8'(SEC_WRAP - 1);

   state_t     state, state_nx;
   logic       ss_prev, mode_prev;
   logic       start_edge, mode_chg;
   logic [7:0] preset_min, init_msb;
   logic [7:0] up_msb, up_lsb, dn_msb, dn_lsb;
   logic       term_up, term_dn, term_hit;
   logic [7:0] msb_nx, lsb_nx;
   logic       stopped_nx, expired_nx;

   assign start_edge = StartStop & ~ss_prev;
   assign mode_chg   = ModeSel ^ mode_prev;
   assign fsm_state  = state;

   // Mode B preset is TimeControl+1 minutes, clamped so it never exceeds MAX_MIN.
   assign preset_min = {5'd0, TimeControl} + 8'd1;
   assign init_msb   = ModeSel ? ((preset_min > MAX_M) ? MAX_M : preset_min) : 8'd0;

   always_comb begin
      up_msb = MSB;
      up_lsb = LSB + 8'd1;
      if (LSB == SEC_LAST) begin
         up_lsb = 8'd0;
         up_msb = MSB + 8'd1;
      end
      dn_msb = MSB;
      dn_lsb = LSB - 8'd1;
      if (LSB == 8'd0) begin
         dn_lsb = SEC_LAST;
         dn_msb = MSB - 8'd1;
      end
   end

   assign term_up  = (up_msb == MAX_M) && (up_lsb == SEC_LAST);
   assign term_dn  = (dn_msb == 8'd0) && (dn_lsb == 8'd0);
   assign term_hit = ModeSel ? term_dn : term_up;

   // State and output register; Reset loads the edge/mode history from the live inputs
   // so a level already high at release does not look like a fresh event.
   always_ff @(posedge CLK_1Hz) begin
      if (Reset) begin
         state     <= IDLE;
         MSB       <= init_msb;
         LSB       <= 8'd0;
         Stopped   <= 1'b1;
         Expired   <= 1'b0;
         ss_prev   <= StartStop;
         mode_prev <= ModeSel;
      end else begin
         state     <= state_nx;
         MSB       <= msb_nx;
         LSB       <= lsb_nx;
         Stopped   <= stopped_nx;
         Expired   <= expired_nx;
         ss_prev   <= StartStop;
         mode_prev <= ModeSel;
      end
   end

   always_comb begin
      state_nx = state;
      if (Clear || mode_chg) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_edge) state_nx = RUN;
            RUN:     if (start_edge) state_nx = PAUSE;
                     else if (term_hit) state_nx = DONE;
            PAUSE:   if (start_edge) state_nx = RUN;
            default: state_nx = state;
         endcase
      end
   end

   always_comb begin
      msb_nx     = MSB;
      lsb_nx     = LSB;
      expired_nx = 1'b0;
      if (Clear || mode_chg) begin
         msb_nx = init_msb;
         lsb_nx = 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (!start_edge) begin
                  msb_nx = init_msb;
                  lsb_nx = 8'd0;
               end
            end
            RUN: begin
               if (!start_edge) begin
                  msb_nx     = ModeSel ? dn_msb : up_msb;
                  lsb_nx     = ModeSel ? dn_lsb : up_lsb;
                  expired_nx = term_hit;
               end
            end
            default: begin
               msb_nx = MSB;
               lsb_nx = LSB;
            end
         endcase
      end
      stopped_nx = (state_nx != RUN);
   end

endmodule

// File: doc/two_mode_timer.md
Name: two_mode_timer

Overview:
Timekeeping core of the two-mode timer. It produces the MSB (minutes) and LSB (seconds) time values and the Stopped flag that the Flasher and display logic consume.
- Mode A (ModeSel=0): count-up stopwatch.
- Mode B (ModeSel=1): countdown from a preset selected by TimeControl.
- Includes a run/pause/done state machine driven by a StartStop button and a Clear button.

Parameters:
MAX_MIN, 99, terminal minute value for Mode A; also the clamp for Mode B presets.
SEC_WRAP, 60, seconds modulus; LSB ranges 0..SEC_WRAP-1.

Ports:
CLK_1Hz  input  1  timer clock; one edge per second; all state changes on rising edge
Reset  input  1  synchronous, active-high reset
ModeSel  input  1  0 = Mode A count-up, 1 = Mode B countdown
TimeControl  input  3  Mode B preset: minutes = TimeControl+1 (1..8), seconds = 0
StartStop  input  1  run/pause request level; rising edge detected internally
Clear  input  1  level; reload initial value and return to IDLE
MSB  output  8  minutes, unsigned binary (not BCD)
LSB  output  8  seconds, unsigned binary, 0..59
Stopped  output  1  1 when not counting (IDLE, PAUSE, DONE)
Expired  output  1  one-cycle pulse on the edge the terminal value is reached

Behaviour:
- Reset (sampled on a CLK_1Hz edge):
  - State=IDLE.
  - MSB/LSB load the initial value for the current ModeSel: Mode A 0:00; Mode B (TimeControl+1):00.
  - Stopped=1, Expired=0.
  - StartStop edge register and ModeSel history register are cleared/loaded so neither produces a spurious event next cycle.
- Start edge: StartStop=1 now and 0 on the previous edge. A level held high yields exactly one event.
- Mode change: ModeSel differs from its value registered on the previous edge.
- Priority per edge: Reset > Clear > mode change > start edge > counting.
- States:
  - IDLE:
    - Outputs hold the initial value. TimeControl changes reload the Mode B preset immediately, at the next edge.
    - A start edge moves to RUN. The value is unchanged on that edge.
  - RUN:
    - Every edge updates the count.
    - A start edge moves to PAUSE. The count does not update on that edge.
  - PAUSE:
    - Value held; TimeControl ignored.
    - A start edge moves to RUN.
  - DONE:
    - Value held at the terminal value.
    - A start edge is ignored; only Clear, mode change or Reset exit DONE.
- Clear or mode change in any state: reload the initial value for the new ModeSel, go to IDLE. Stopped=1 from the same edge.
- Mode A count (RUN):
  - LSB+1.
  - At LSB=SEC_WRAP-1: LSB=0, MSB+1.
  - On reaching MSB=MAX_MIN, LSB=SEC_WRAP-1: go to DONE with Expired=1 on that edge. No wrap to 0:00.
- Mode B count (RUN):
  - LSB-1.
  - At LSB=0 with MSB>0: LSB=SEC_WRAP-1, MSB-1.
  - On reaching 0:00: go to DONE with Expired=1 on that edge.
  - The preset is never 0:00, so a countdown always lasts at least 60 edges.
- Stopped=0 only in RUN. It is registered and changes on the same edge as the state.
- Latency:
  - Start edge on edge n → Stopped=0 after edge n. First count step at edge n+1.
  - Pause edge → Stopped=1 after that edge, and the count is frozen from that edge on.
- Expired is high for exactly one cycle, even if DONE persists. Reset or Clear on the terminal edge suppresses it.
- MSB/LSB never leave their legal ranges: LSB ≤ 59, MSB ≤ MAX_MIN.

Test Plan:
- Reset → MSB=0, LSB=0, Stopped=1. Pulse StartStop; after 61 further edges → MSB=1, LSB=1, Stopped=0.
- Mode B, TimeControl=3'b100, Reset → MSB=5, LSB=0. Start, one count edge → MSB=4, LSB=59. After 300 count edges → 0:00, Expired pulses once, Stopped=1, value holds 0:00 for 10 more edges.
- Mode A running at 0:10:
  - StartStop pulse → frozen at 0:10 with Stopped=1 for 5 edges.
  - StartStop held high for 5 edges → only one resume; count continues to 0:11.
- Mode A preloaded near terminal by counting (MAX_MIN=1 override): reaching 1:59 → DONE, Expired=1 once. A further StartStop edge leaves 1:59 and Stopped=1.
- Mode A running at 0:20; toggle ModeSel to 1 with TimeControl=3'b001 → next edge MSB=2, LSB=0, IDLE, Stopped=1. Clear and StartStop asserted together → Clear wins: stays IDLE at 2:00.
- Reset asserted mid-countdown at 3:17 (Mode B, TimeControl=3'b010) → next edge 3:00, IDLE, Expired=0. The StartStop level already high at reset release does not start the timer.
